fpioa_cfg_seq: RTL and testbench

Configuration sequencer and access arbiter for the FPIOA pin-mux register file. After reset it writes a compile-time default pin map into the FPIOA output-select (0x00–0x1C) and low input-select (0x80–0x8C) registers, then grants the CPU bus access. Sits between the sysio bus decoder and the FPIOA register port. It also supports hardware-triggered reload of the defaults and an optional write lock.

---
 rtl/fpioa_cfg_seq.sv | 182 ++++++++++++++++++
 tb/tb_fpioa_cfg_seq.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpioa_cfg_seq.sv
// FPIOA pin-mux configuration sequencer: boot-time default load, CPU access arbitration, reload.
// Optional write lock enabled by defining FPIOA_CFG_LOCK_EN.
module fpioa_cfg_seq #(
  parameter logic [255:0] DEF_OT = 256'h0,
  parameter logic [127:0] DEF_IN = 128'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_we_i,
  input  logic [7:0]  cpu_waddr_i,
  input  logic [31:0] cpu_data_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic        cpu_rd_i,
  input  logic [7:0]  cpu_raddr_i,
  output logic        cpu_ready_o,
  output logic        cpu_rvalid_o,
  output logic [31:0] cpu_rdata_o,
  input  logic        reload_i,
  input  logic        lock_i,
  output logic        boot_done_o,
  output logic        locked_o,
  output logic        lock_err_o,
  output logic        fp_we_o,
  output logic [7:0]  fp_waddr_o,
  output logic [31:0] fp_data_o,
  output logic [3:0]  fp_sel_o,
  output logic        fp_rd_o,
  output logic [7:0]  fp_raddr_o,
  input  logic [31:0] fp_rdata_i
);

  typedef enum logic [1:0] {StBoot, StRun, StDrain} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        fp_we_q, fp_we_d;
  logic [7:0]  fp_waddr_q, fp_waddr_d;
  logic [31:0] fp_data_q, fp_data_d;
  logic [3:0]  fp_sel_q, fp_sel_d;
  logic        fp_rd_q, fp_rd_d;
  logic [7:0]  fp_raddr_q, fp_raddr_d;
  logic        rvalid_q, rvalid_d;
  logic        lock_err_d;
  logic        wr_blocked;

  // Words 0-7: four 7-bit output selects per word; words 8-11: four 5-bit input selects.
  logic [11:0][31:0] boot_rom;
  logic [7:0]        boot_addr;

  for (genvar w = 0; w < 8; w++) begin : g_ot
    for (genvar b = 0; b < 4; b++) begin : g_b
      assign boot_rom[w][8*b +: 8] = {1'b0, DEF_OT[32*w + 8*b +: 7]};
    end
  end
  for (genvar w = 0; w < 4; w++) begin : g_in
    for (genvar b = 0; b < 4; b++) begin : g_b
      assign boot_rom[8+w][8*b +: 8] = {3'b000, DEF_IN[32*w + 8*b +: 5]};
    end
  end

  assign boot_addr = cnt_q[3] ? {4'b1000, cnt_q[1:0], 2'b00} : {3'b000, cnt_q[2:0], 2'b00};

`ifdef FPIOA_CFG_LOCK_EN
  logic locked_q, locked_d;
  logic lock_err_q;

  assign wr_blocked = locked_q;
  assign locked_d   = locked_q | lock_i;
  assign locked_o   = locked_q;
  assign lock_err_o = lock_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      locked_q   <= 1'b0;
      lock_err_q <= 1'b0;
    end else begin
      locked_q   <= locked_d;
      lock_err_q <= lock_err_d;
    end
  end
`else
  logic unused_lock;

  assign unused_lock = lock_i ^ lock_err_d;
  assign wr_blocked  = 1'b0;
  assign locked_o    = 1'b0;
  assign lock_err_o  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StBoot;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot:  if (cnt_q == 4'd11) state_d = StRun;
      StRun:   if (reload_i) state_d = StDrain;
      StDrain: state_d = StBoot;
      default: state_d = StBoot;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    fp_we_d    = 1'b0;
    fp_waddr_d = 8'h00;
    fp_data_d  = 32'h0;
    fp_sel_d   = 4'h0;
    fp_rd_d    = 1'b0;
    fp_raddr_d = 8'h00;
    lock_err_d = 1'b0;
    // A read issued in the last RUN cycle still completes after the state moves on.
    rvalid_d   = fp_rd_q;
    unique case (state_q)
      StBoot: begin
        fp_we_d    = 1'b1;
        fp_waddr_d = boot_addr;
        fp_data_d  = boot_rom[cnt_q];
        fp_sel_d   = 4'hF;
        if (cnt_q != 4'd11) cnt_d = cnt_q + 4'd1;
      end
      StRun: begin
        if (cpu_we_i) begin
          if (wr_blocked) begin
            lock_err_d = 1'b1;
          end else begin
            fp_we_d    = 1'b1;
            fp_waddr_d = cpu_waddr_i;
            fp_data_d  = cpu_data_i;
            fp_sel_d   = cpu_sel_i;
          end
        end else if (cpu_rd_i) begin
          // FPIOA selects the read bank from waddr bit 7.
          fp_rd_d    = 1'b1;
          fp_raddr_d = cpu_raddr_i;
          fp_waddr_d = cpu_raddr_i;
        end
      end
      StDrain: cnt_d = 4'd0;
      default: cnt_d = 4'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= 4'd0;
      fp_we_q    <= 1'b0;
      fp_waddr_q <= 8'h00;
      fp_data_q  <= 32'h0;
      fp_sel_q   <= 4'h0;
      fp_rd_q    <= 1'b0;
      fp_raddr_q <= 8'h00;
      rvalid_q   <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      fp_we_q    <= fp_we_d;
      fp_waddr_q <= fp_waddr_d;
      fp_data_q  <= fp_data_d;
      fp_sel_q   <= fp_sel_d;
      fp_rd_q    <= fp_rd_d;
      fp_raddr_q <= fp_raddr_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign cpu_ready_o  = (state_q == StRun);
  assign boot_done_o  = (state_q == StRun);
  assign cpu_rvalid_o = rvalid_q;
  assign cpu_rdata_o  = rvalid_q ? fp_rdata_i : 32'h0;
  assign fp_we_o      = fp_we_q;
  assign fp_waddr_o   = fp_waddr_q;
  assign fp_data_o    = fp_data_q;
  assign fp_sel_o     = fp_sel_q;
  assign fp_rd_o      = fp_rd_q;
  assign fp_raddr_o   = fp_raddr_q;

endmodule

// File: tb/tb_fpioa_cfg_seq.sv
// Directed bench for fpioa_cfg_seq: boot load table, CPU vector table, reload/reset/lock sequences.
module tb_fpioa_cfg_seq;

  localparam logic [255:0] DefOt =
    256'h201f1e1d_1c1b1a19_18171615_14131211_100f0e0d_0c0b0a09_08070605_04030201;
  localparam logic [127:0] DefIn = 128'h00000000_00000000_000000ff_00000005;

  logic        clk, rst;
  logic        cpu_we_i, cpu_rd_i, reload_i, lock_i;
  logic [7:0]  cpu_waddr_i, cpu_raddr_i;
  logic [31:0] cpu_data_i, fp_rdata_i;
  logic [3:0]  cpu_sel_i;
  logic        cpu_ready_o, cpu_rvalid_o, boot_done_o, locked_o, lock_err_o;
  logic [31:0] cpu_rdata_o, fp_data_o;
  logic        fp_we_o, fp_rd_o;
  logic [7:0]  fp_waddr_o, fp_raddr_o;
  logic [3:0]  fp_sel_o;

  fpioa_cfg_seq #(.DEF_OT(DefOt), .DEF_IN(DefIn)) dut (
    .clk(clk), .rst(rst),
    .cpu_we_i(cpu_we_i), .cpu_waddr_i(cpu_waddr_i), .cpu_data_i(cpu_data_i),
    .cpu_sel_i(cpu_sel_i), .cpu_rd_i(cpu_rd_i), .cpu_raddr_i(cpu_raddr_i),
    .cpu_ready_o(cpu_ready_o), .cpu_rvalid_o(cpu_rvalid_o), .cpu_rdata_o(cpu_rdata_o),
    .reload_i(reload_i), .lock_i(lock_i), .boot_done_o(boot_done_o),
    .locked_o(locked_o), .lock_err_o(lock_err_o),
    .fp_we_o(fp_we_o), .fp_waddr_o(fp_waddr_o), .fp_data_o(fp_data_o), .fp_sel_o(fp_sel_o),
    .fp_rd_o(fp_rd_o), .fp_raddr_o(fp_raddr_o), .fp_rdata_i(fp_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } boot_t;

  typedef struct packed {
    logic        we;
    logic        rd;
    logic [7:0]  waddr;
    logic [7:0]  raddr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [31:0] rdata;
    logic        e_we;
    logic        e_rd;
    logic [7:0]  e_waddr;
    logic [7:0]  e_raddr;
    logic [31:0] e_data;
    logic [3:0]  e_sel;
    logic        e_rvalid;
  } vec_t;

  boot_t boot_tbl[12];
  vec_t  vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Assumes rst was just deasserted at a falling edge.
  task automatic boot_check();
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      chk($sformatf("boot%0d_we", n), fp_we_o, 1);
      chk($sformatf("boot%0d_addr", n), fp_waddr_o, boot_tbl[n].addr);
      chk($sformatf("boot%0d_data", n), fp_data_o, boot_tbl[n].data);
      chk($sformatf("boot%0d_sel", n), fp_sel_o, 4'hF);
      chk($sformatf("boot%0d_done", n), boot_done_o, (n == 11));
      chk($sformatf("boot%0d_ready", n), cpu_ready_o, (n == 11));
    end
    @(negedge clk);
    chk("boot_end_we", fp_we_o, 0);
    chk("boot_end_done", boot_done_o, 1);
  endtask

  task automatic do_reload(input logic rd_req);
    int low;
    int wr;
    chk("reload_pre_ready", cpu_ready_o, 1);
    cpu_we_i    = ~rd_req;
    cpu_rd_i    = rd_req;
    cpu_waddr_i = 8'h08;
    cpu_raddr_i = 8'h84;
    cpu_data_i  = 32'h0000_0055;
    cpu_sel_i   = 4'hF;
    reload_i    = 1'b1;
    fp_rdata_i  = 32'h0000_1f00;
    @(negedge clk);
    cpu_we_i = 1'b0;
    cpu_rd_i = 1'b0;
    reload_i = 1'b0;
    chk("drain_ready", cpu_ready_o, 0);
    if (rd_req) begin
      chk("drain_fp_rd", fp_rd_o, 1);
      chk("drain_fp_raddr", fp_raddr_o, 8'h84);
      chk("drain_fp_we", fp_we_o, 0);
    end else begin
      chk("drain_fp_we", fp_we_o, 1);
      chk("drain_fp_waddr", fp_waddr_o, 8'h08);
      chk("drain_fp_data", fp_data_o, 32'h55);
    end
    low = 1;
    wr  = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      reload_i = (i == 4);
      if (i == 0) begin
        chk("reload_rvalid", cpu_rvalid_o, rd_req);
        if (rd_req) chk("reload_rdata", cpu_rdata_o, 32'h0000_1f00);
      end
      if (fp_we_o) begin
        if (wr < 12) begin
          chk($sformatf("reboot%0d_addr", wr), fp_waddr_o, boot_tbl[wr].addr);
          chk($sformatf("reboot%0d_data", wr), fp_data_o, boot_tbl[wr].data);
        end
        wr++;
      end
      if (cpu_ready_o) break;
      low++;
    end
    reload_i = 1'b0;
    chk("reload_writes", wr, 12);
    chk("reload_ready_low", low, 13);
    @(negedge clk);
    chk("reload_end_we", fp_we_o, 0);
  endtask

  initial begin
    boot_tbl[0]  = '{8'h00, 32'h04030201};
    boot_tbl[1]  = '{8'h04, 32'h08070605};
    boot_tbl[2]  = '{8'h08, 32'h0c0b0a09};
    boot_tbl[3]  = '{8'h0c, 32'h100f0e0d};
    boot_tbl[4]  = '{8'h10, 32'h14131211};
    boot_tbl[5]  = '{8'h14, 32'h18171615};
    boot_tbl[6]  = '{8'h18, 32'h1c1b1a19};
    boot_tbl[7]  = '{8'h1c, 32'h201f1e1d};
    boot_tbl[8]  = '{8'h80, 32'h00000005};
    boot_tbl[9]  = '{8'h84, 32'h0000001f};
    boot_tbl[10] = '{8'h88, 32'h00000000};
    boot_tbl[11] = '{8'h8c, 32'h00000000};

    //             we    rd    waddr  raddr  wdata         sel   rdata
    //             e_we  e_rd  e_wa   e_ra   e_data        e_sel e_rvalid
    vecs[0] = '{1'b1, 1'b0, 8'h04, 8'h00, 32'h00000020, 4'h1, 32'h0,
                1'b1, 1'b0, 8'h04, 8'h00, 32'h00000020, 4'h1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 8'h00, 8'h80, 32'h0,        4'h0, 32'h05030201,
                1'b0, 1'b1, 8'h80, 8'h80, 32'h0,        4'h0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 8'h10, 8'h84, 32'hdeadbeef, 4'hF, 32'h11111111,
                1'b1, 1'b0, 8'h10, 8'h00, 32'hdeadbeef, 4'hF, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 8'h00, 8'h1c, 32'h0,        4'h0, 32'ha5a5a5a5,
                1'b0, 1'b1, 8'h1c, 8'h1c, 32'h0,        4'h0, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 8'h8c, 8'h00, 32'h00001234, 4'hA, 32'h0,
                1'b1, 1'b0, 8'h8c, 8'h00, 32'h00001234, 4'hA, 1'b0};

    rst = 1'b1;
    cpu_we_i = 1'b1; cpu_rd_i = 1'b0; reload_i = 1'b0; lock_i = 1'b0;
    cpu_waddr_i = 8'h04; cpu_raddr_i = 8'h00; cpu_data_i = 32'hffffffff; cpu_sel_i = 4'hF;
    fp_rdata_i = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_fp_we", fp_we_o, 0);
    chk("rst_fp_waddr", fp_waddr_o, 0);
    chk("rst_fp_data", fp_data_o, 0);
    chk("rst_fp_sel", fp_sel_o, 0);
    chk("rst_fp_rd", fp_rd_o, 0);
    chk("rst_fp_raddr", fp_raddr_o, 0);
    chk("rst_ready", cpu_ready_o, 0);
    chk("rst_rvalid", cpu_rvalid_o, 0);
    chk("rst_boot_done", boot_done_o, 0);
    chk("rst_locked", locked_o, 0);
    chk("rst_lock_err", lock_err_o, 0);
    cpu_we_i = 1'b0;
    rst = 1'b0;
    boot_check();

    for (int v = 0; v < 5; v++) begin
      chk($sformatf("v%0d_ready", v), cpu_ready_o, 1);
      cpu_we_i    = vecs[v].we;
      cpu_rd_i    = vecs[v].rd;
      cpu_waddr_i = vecs[v].waddr;
      cpu_raddr_i = vecs[v].raddr;
      cpu_data_i  = vecs[v].wdata;
      cpu_sel_i   = vecs[v].sel;
      @(negedge clk);
      cpu_we_i = 1'b0;
      cpu_rd_i = 1'b0;
      chk($sformatf("v%0d_fp_we", v), fp_we_o, vecs[v].e_we);
      chk($sformatf("v%0d_fp_rd", v), fp_rd_o, vecs[v].e_rd);
      chk($sformatf("v%0d_fp_waddr", v), fp_waddr_o, vecs[v].e_waddr);
      if (vecs[v].e_rd) chk($sformatf("v%0d_fp_raddr", v), fp_raddr_o, vecs[v].e_raddr);
      if (vecs[v].e_we) begin
        chk($sformatf("v%0d_fp_data", v), fp_data_o, vecs[v].e_data);
        chk($sformatf("v%0d_fp_sel", v), fp_sel_o, vecs[v].e_sel);
      end
      chk($sformatf("v%0d_early_rvalid", v), cpu_rvalid_o, 0);
      fp_rdata_i = vecs[v].rdata;
      @(negedge clk);
      chk($sformatf("v%0d_rvalid", v), cpu_rvalid_o, vecs[v].e_rvalid);
      if (vecs[v].e_rvalid) chk($sformatf("v%0d_rdata", v), cpu_rdata_o, vecs[v].rdata);
      chk($sformatf("v%0d_idle_we", v), fp_we_o, 0);
      chk($sformatf("v%0d_idle_rd", v), fp_rd_o, 0);
      @(negedge clk);
      chk($sformatf("v%0d_rvalid_pulse", v), cpu_rvalid_o, 0);
    end

    do_reload(1'b0);
    do_reload(1'b1);

    // Reset during a read cancels the pending rvalid.
    cpu_rd_i = 1'b1;
    cpu_raddr_i = 8'h88;
    @(negedge clk);
    cpu_rd_i = 1'b0;
    chk("midrd_fp_rd", fp_rd_o, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrd_rvalid", cpu_rvalid_o, 0);
    chk("midrd_fp_rd_clr", fp_rd_o, 0);
    chk("midrd_done", boot_done_o, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("midboot_we", fp_we_o, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midboot_rst_we", fp_we_o, 0);
    chk("midboot_rst_addr", fp_waddr_o, 0);
    rst = 1'b0;
    boot_check();

`ifdef FPIOA_CFG_LOCK_EN
    lock_i = 1'b1;
    @(negedge clk);
    lock_i = 1'b0;
    chk("lock_set", locked_o, 1);
    chk("lock_ready", cpu_ready_o, 1);
    cpu_we_i = 1'b1; cpu_waddr_i = 8'h00; cpu_data_i = 32'h7f; cpu_sel_i = 4'hF;
    @(negedge clk);
    cpu_we_i = 1'b0;
    chk("lock_fp_we", fp_we_o, 0);
    chk("lock_err", lock_err_o, 1);
    @(negedge clk);
    chk("lock_err_pulse", lock_err_o, 0);
    do_reload(1'b1);
    chk("lock_kept", locked_o, 1);
`else
    lock_i = 1'b1;
    @(negedge clk);
    lock_i = 1'b0;
    chk("nolock_locked", locked_o, 0);
    cpu_we_i = 1'b1; cpu_waddr_i = 8'h00; cpu_data_i = 32'h7f; cpu_sel_i = 4'hF;
    @(negedge clk);
    cpu_we_i = 1'b0;
    chk("nolock_fp_we", fp_we_o, 1);
    chk("nolock_data", fp_data_o, 32'h7f);
    chk("nolock_err", lock_err_o, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
